tmds_word_decoder: RTL



---
 rtl/tmds_word_decoder.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/tmds_word_decoder.sv
// tmds_word_decoder: finds word alignment of one TMDS channel from control
// token runs, then decodes each aligned word to pixel data or control.
module tmds_word_decoder #(
   parameter int CTRL_RUN      = 8,
   parameter int SEARCH_WINDOW = 2048
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] tmds_in,
   output logic [7:0] data_out,
   output logic [1:0] ctrl_out,
   output logic       de,
   output logic       locked,
   output logic [3:0] slip
);

   localparam int TW = $clog2(SEARCH_WINDOW);
   localparam int RW = $clog2(CTRL_RUN + 1);

   typedef enum logic {
      SEARCH,
      LOCKED
   } state_t;

   state_t        state_q, state_d;
   logic [9:0]    w_prev_q;
   logic [9:0]    a_q, a_d;
   logic [19:0]   cat;
   logic [RW-1:0] run_q, run_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [1:0]    hold_q, hold_d;
   logic [3:0]    slip_q, slip_d;
   logic [7:0]    data_q, data_d;
   logic [1:0]    ctrl_q, ctrl_d;
   logic          de_q, de_d;

   logic          is_ctrl;
   logic [1:0]    tok;
   logic [7:0]    dd, qd;
   logic          qual, expire, holding;

   assign cat = {tmds_in, w_prev_q};
   assign a_d = 10'(cat >> slip_q);

   always_comb begin
      is_ctrl = 1'b1;
      tok     = 2'b00;
      unique case (a_q)
         10'h354: tok = 2'b00;
         10'h0AB: tok = 2'b01;
         10'h154: tok = 2'b10;
         10'h2AB: tok = 2'b11;
         default: is_ctrl = 1'b0;
      endcase
   end

   always_comb begin
      qd    = '0;
      dd    = a_q[9] ? ~a_q[7:0] : a_q[7:0];
      qd[0] = dd[0];
      for (int i = 1; i < 8; i++) begin
         qd[i] = a_q[8] ? (dd[i] ^ dd[i-1])
                        : ~(dd[i] ^ dd[i-1]);
      end
   end

   // Words in the pipeline right after a slip are at the old rotation.
   assign holding = (hold_q != 2'd0);
   assign expire  = (timer_q == '1);
   assign qual    = !holding && is_ctrl &&
                    (run_q == RW'(CTRL_RUN - 1));

   always_comb begin
      state_d = state_q;
      slip_d  = slip_q;
      timer_d = timer_q + TW'(1);
      hold_d  = holding ? hold_q - 2'd1 : 2'd0;
      if (holding || !is_ctrl) begin
         run_d = '0;
      end else if (run_q == RW'(CTRL_RUN)) begin
         run_d = run_q;
      end else begin
         run_d = run_q + RW'(1);
      end
      unique case (state_q)
         SEARCH: begin
            if (qual) begin
               state_d = LOCKED;
               timer_d = '0;
            end else if (expire) begin
               slip_d  = (slip_q == 4'd9) ? 4'd0
                                          : slip_q + 4'd1;
               timer_d = '0;
               run_d   = '0;
               hold_d  = 2'd2;
            end
         end
         LOCKED: begin
            if (qual) begin
               timer_d = '0;
            end else if (expire) begin
               state_d = SEARCH;
               timer_d = '0;
               run_d   = '0;
            end
         end
      endcase
   end

   always_comb begin
      data_d = data_q;
      ctrl_d = ctrl_q;
      de_d   = 1'b0;
      if (is_ctrl) begin
         ctrl_d = tok;
      end else begin
         data_d = qd;
         de_d   = (state_d == LOCKED);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= SEARCH;
         w_prev_q <= '0;
         a_q      <= '0;
         run_q    <= '0;
         timer_q  <= '0;
         hold_q   <= '0;
         slip_q   <= '0;
         data_q   <= '0;
         ctrl_q   <= '0;
         de_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         w_prev_q <= tmds_in;
         a_q      <= a_d;
         run_q    <= run_d;
         timer_q  <= timer_d;
         hold_q   <= hold_d;
         slip_q   <= slip_d;
         data_q   <= data_d;
         ctrl_q   <= ctrl_d;
         de_q     <= de_d;
      end
   end

   assign data_out = data_q;
   assign ctrl_out = ctrl_q;
   assign de       = de_q;
   assign locked   = (state_q == LOCKED);
   assign slip     = slip_q;

endmodule
